// File: rtl/mem_pkg.sv
// Shared command encodings, bus widths and types for the two-port memory arbiter.
package mem_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 2;

    // A command of 0 is not listed here and is therefore treated like MNONE.
    localparam logic [CMD_W-1:0] MREAD  = 2'd1;
    localparam logic [CMD_W-1:0] MNONE  = 2'd2;
    localparam logic [CMD_W-1:0] MWRITE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic cmd_valid(input logic [CMD_W-1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner select: a lone request wins outright, a tie goes to the
// requester named by ptr_i (0 -> requester 0, 1 -> requester 1).
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_c_o
);

    always_comb begin
        gnt_c_o = req_i;
        if (&req_i) begin
            gnt_c_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port RAM, one transaction per
// IDLE/ACCESS/DONE pass. Define MEM_ARB_RR_EN for round-robin ties; otherwise requester 0 always wins.
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ack,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        grant
);

    state_e            state_q, state_d;
    mem_req_t          txn_q, txn_d;
    mem_req_t          req0, req1;
    logic              owner_q, owner_d;
    logic [1:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        req_vld;
    logic [1:0]        arb_gnt;
    logic              ptr;
    logic              rd_bypass;

    assign req0    = '{cmd: req0_cmd, addr: req0_addr, wdata: req0_wdata};
    assign req1    = '{cmd: req1_cmd, addr: req1_addr, wdata: req1_wdata};
    assign req_vld = {cmd_valid(req1_cmd), cmd_valid(req0_cmd)};

    rr_arbiter2 u_arb (
        .req_i   (req_vld),
        .ptr_i   (ptr),
        .gnt_c_o (arb_gnt)
    );

`ifdef MEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Tie priority passes to whichever requester was not just granted.
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == ST_IDLE) && (|req_vld)) begin
            ptr_d = ~arb_gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        owner_d  = owner_q;
        grant_d  = 2'b00;
        we_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                // Requests are captured only here; later changes by the requester are ignored.
                if (|req_vld) begin
                    state_d = ST_ACCESS;
                    owner_d = arb_gnt[1];
                    txn_d   = arb_gnt[1] ? req1 : req0;
                    grant_d = arb_gnt;
                    we_d    = (txn_d.cmd == MWRITE);
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (txn_q.cmd == MREAD) begin
                    if (owner_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            txn_q    <= '0;
            owner_q  <= 1'b0;
            grant_q  <= 2'b00;
            we_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // RAM data only arrives in DONE, so the ack cycle forwards it while the register loads.
    assign rd_bypass  = (state_q == ST_DONE) && (txn_q.cmd == MREAD);
    assign req0_rdata = (rd_bypass && !owner_q) ? ram_rdata : rdata0_q;
    assign req1_rdata = (rd_bypass &&  owner_q) ? ram_rdata : rdata1_q;
    assign req0_ack   = ack0_q;
    assign req1_ack   = ack1_q;
    assign ram_addr   = txn_q.addr;
    assign ram_wdata  = txn_q.wdata;
    assign ram_we     = we_q & ~reset;
    assign grant      = grant_q;

    a_single_ack: assert property (@(posedge clk) disable iff (reset)
        !(ack0_q && ack1_q));
    a_grant_access: assert property (@(posedge clk) disable iff (reset)
        (state_q != ST_ACCESS) |-> (grant_q == 2'b00));
    a_we_access: assert property (@(posedge clk) disable iff (reset)
        (state_q != ST_ACCESS) |-> !we_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single system clock; all state changes on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req0_cmd  in  2  requester 0 (CPU) command; MREAD=1, MWRITE=3, MNONE=2; 0 treated as MNONE.
REQ-004 req0_addr  in  9  requester 0 word address.
REQ-005 req0_wdata  in  16  requester 0 write data.
REQ-006 req0_rdata  out  16  requester 0 read data; valid in ack cycle.
REQ-007 req0_ack  out  1  one-cycle completion pulse to requester 0.
REQ-008 req1_cmd, req1_addr, req1_wdata, req1_rdata, req1_ack  same widths/meaning for requester 1 (DMA/debug port).
REQ-009 ram_addr  out  9  single-port RAM address.
REQ-010 ram_wdata  out  16  RAM write data.
REQ-011 ram_we  out  1  RAM write enable; RAM writes on posedge clk when high.
REQ-012 ram_rdata  in  16  RAM read data; valid one cycle after ram_addr presented.
REQ-013 grant  out  2  one-hot owner of current transaction; 00 when idle.

Function
REQ-014 FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS (any valid request), ACCESS->DONE, DONE->IDLE; no other transitions.
REQ-015 IDLE: if exactly one requester has MREAD/MWRITE, it wins; winner's cmd, addr, wdata registered; grant set one-hot.
REQ-016 Both requesting in IDLE: winner chosen per REQ-027/REQ-028.
REQ-017 ACCESS: ram_addr = latched addr, ram_wdata = latched wdata; ram_we = 1 only if latched cmd is MWRITE.
REQ-018 DONE: for MREAD, winner's rdata register loads ram_rdata; winner's ack = 1 for exactly this cycle; loser's ack = 0, rdata held.
REQ-019 Latency: request present in IDLE cycle N -> ack in cycle N+2; back-to-back throughput one transaction per 3 cycles.
REQ-020 Requester holds cmd/addr/wdata until ack; arbiter samples them only in IDLE, so changes after sampling are ignored.
REQ-021 Requester still asserting cmd in the cycle after ack is treated as a new request and re-arbitrated.
REQ-022 reqN_rdata retains last read value between transactions; unaffected by writes.
REQ-023 ram_we = 0 and grant = 00 in IDLE and DONE; never two acks in the same cycle.

Reset
REQ-024 reset in any state -> IDLE next cycle; ack 0, rdata 0, grant 00, ram_addr 0, ram_wdata 0, round-robin pointer favours requester 0.
REQ-025 ram_we SHALL be forced 0 while reset is high, so a write in ACCESS concurrent with reset is not committed.
REQ-026 Transaction aborted by reset produces no ack; requester must reissue.

Configuration
REQ-027 MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted most recently wins; pointer updates on each grant.
REQ-028 MEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-029 Shared package mem_pkg holds MREAD/MNONE/MWRITE encodings, address width 9, data width 16, FSM state typedef.
REQ-030 Winner selection in sub-module rr_arbiter2 (2-way, pointer input, one-hot grant out); mem_arbiter instantiates it.

Verification
REQ-031 req0 MWRITE addr 0x005 data 0xABCD alone -> ram_we=1 addr 0x005 one cycle later; req0_ack two cycles after sample; grant=01.
REQ-032 req1 MREAD addr 0x005 after REQ-031 -> req1_rdata=0xABCD with req1_ack; req0_rdata unchanged.
REQ-033 Both MREAD continuously from reset, RR_EN -> acks alternate req0,req1,req0,... every 3 cycles; without RR_EN -> only req0 acked.
REQ-034 reset asserted during ACCESS of MWRITE 0x1234 to 0x010 -> ram_we 0, no ack, later read of 0x010 returns prior value.
REQ-035 cmd=0 or MNONE on both ports -> FSM stays IDLE, grant 00, no ram_we, no ack.
REQ-036 req0 changes addr 0x003->0x007 during ACCESS -> RAM accessed at 0x003.
